mem_arbiter: RTL

- Sits directly upstream of the shared single-port RAM (12-bit data, 256 deep, 1-cycle registered read, read-first on write).
- Arbitrates load/store requests from NUM_CORES cores using round-robin and drives the RAM address, dataIn and WriteEn.
- Captures the RAM's dataOut and returns it to the winning core with a one-cycle response pulse.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter_rr_arbiter.sv | 69 ++++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the round-robin memory arbiter.
package mem_arb_pkg;

    localparam int DEFAULT_NUM_CORES  = 4;
    localparam int DEFAULT_DATA_WIDTH = 12;
    localparam int DEFAULT_DEPTH      = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } arb_state_e;

    // Index width of a core number; never narrower than one bit.
    function automatic int grant_width(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core request/response bus plus the RAM port of the memory arbiter.
interface mem_arbiter_if #(
    parameter int NUM_CORES  = mem_arb_pkg::DEFAULT_NUM_CORES,
    parameter int DATA_WIDTH = mem_arb_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(mem_arb_pkg::DEFAULT_DEPTH)
);
    logic [NUM_CORES-1:0]            reqValid;
    logic [NUM_CORES-1:0]            reqWrite;
    logic [NUM_CORES*ADDR_WIDTH-1:0] reqAddr;
    logic [NUM_CORES*DATA_WIDTH-1:0] reqData;
    logic [NUM_CORES-1:0]            reqReady;
    logic [NUM_CORES-1:0]            respValid;
    logic [DATA_WIDTH-1:0]           respData;
    logic [ADDR_WIDTH-1:0]           ramAddress;
    logic [DATA_WIDTH-1:0]           ramDataIn;
    logic                            ramWriteEn;
    logic [DATA_WIDTH-1:0]           ramDataOut;

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqData, ramDataOut,
        output reqReady, respValid, respData, ramAddress, ramDataIn, ramWriteEn
    );

    modport master (
        output reqValid, reqWrite, reqAddr, reqData, ramDataOut,
        input  reqReady, respValid, respData, ramAddress, ramDataIn, ramWriteEn
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational one-hot picker: round-robin from last_grant+1, or strict
// lowest-index priority when MEM_ARB_FIXED_PRIORITY_EN is defined.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES   = DEFAULT_NUM_CORES,
    parameter int GRANT_WIDTH = grant_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0]   req,
    input  logic [GRANT_WIDTH-1:0] last_grant,
    output logic [NUM_CORES-1:0]   grant,
    output logic [GRANT_WIDTH-1:0] grant_idx,
    output logic                   grant_valid
);

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = ^last_grant;

    // Scan from the top down so the lowest-index requester is written last.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx   = GRANT_WIDTH'(i);
                grant_valid = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end
`else
    // Scan the widest offset first so the nearest requester after last_grant wins.
    always_comb begin
        logic [GRANT_WIDTH:0] cand_s;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = '0;
        for (int off = NUM_CORES; off >= 1; off--) begin
            cand_s = {1'b0, last_grant} + (GRANT_WIDTH+1)'(off);
            if (cand_s >= (GRANT_WIDTH+1)'(NUM_CORES)) begin
                cand_s = cand_s - (GRANT_WIDTH+1)'(NUM_CORES);
            end else begin
                cand_s = cand_s;
            end
            if (req[cand_s[GRANT_WIDTH-1:0]]) begin
                grant_idx   = cand_s[GRANT_WIDTH-1:0];
                grant_valid = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates core loads/stores onto a single-port read-first RAM and returns
// the RAM read data as a one-cycle response. MEM_ARB_FIXED_PRIORITY_EN selects
// strict priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CORES  = DEFAULT_NUM_CORES,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int GW = grant_width(NUM_CORES);

    arb_state_e            state_q, state_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [GW-1:0]         win_q, win_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [NUM_CORES-1:0]  gnt_s;
    logic [GW-1:0]         gnt_idx_s;
    logic                  gnt_valid_s;
    logic [NUM_CORES-1:0]  req_ready_s;

    rr_arbiter #(
        .NUM_CORES   (NUM_CORES),
        .GRANT_WIDTH (GW)
    ) u_rr_arbiter (
        .req         (bus.reqValid),
        .last_grant  (last_grant_q),
        .grant       (gnt_s),
        .grant_idx   (gnt_idx_s),
        .grant_valid (gnt_valid_s)
    );

    // Next-state: IDLE and RESPOND both act as accept windows.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        data_d       = data_q;
        req_ready_s  = '0;
        case (state_q)
            IDLE, RESPOND: begin
                if (gnt_valid_s) begin
                    req_ready_s  = gnt_s;
                    win_d        = gnt_idx_s;
                    last_grant_d = gnt_idx_s;
                    wr_d         = bus.reqWrite[gnt_idx_s];
                    addr_d       = bus.reqAddr[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                    data_d       = bus.reqData[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    state_d      = ACCESS;
                end else begin
                    state_d      = IDLE;
                end
            end
            ACCESS:  state_d = RESPOND;
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_CORES - 1);
            win_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    // Outputs; reset gates everything so an in-flight write or response is dropped.
    always_comb begin
        bus.reqReady   = '0;
        bus.respValid  = '0;
        bus.respData   = '0;
        bus.ramAddress = '0;
        bus.ramDataIn  = '0;
        bus.ramWriteEn = 1'b0;
        if (!reset) begin
            bus.reqReady   = req_ready_s;
            bus.ramAddress = addr_q;
            bus.ramDataIn  = data_q;
            bus.ramWriteEn = (state_q == ACCESS) && wr_q;
            if (state_q == RESPOND) begin
                bus.respValid[win_q] = 1'b1;
                bus.respData         = bus.ramDataOut;
            end else begin
                bus.respData = '0;
            end
        end else begin
            bus.reqReady = '0;
        end
    end

endmodule
